// File: rtl/ttl_univ_shift_pkg.sv
// Shared definitions for the universal shift register: mode encodings,
// burst-engine states and the shift-class predicate.
package ttl_univ_shift_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD = 3'b000,
        MODE_SR   = 3'b001,
        MODE_SL   = 3'b010,
        MODE_LOAD = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_ROL  = 3'b101,
        MODE_SRX  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // True for modes that a burst may repeat (shifts and rotates).
    function automatic logic is_shift_mode(input mode_e m);
        case (m)
            MODE_SR, MODE_SL, MODE_ROR, MODE_ROL, MODE_SRX: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ttl_univ_shift_if.sv
// Control/data bundle of the universal shift register.
interface ttl_univ_shift_if
    import ttl_univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 4
);
    logic              CE;
    logic [MODE_W-1:0] MODE;
    logic              DSR;
    logic              DSL;
    logic [WIDTH-1:0]  D;
    logic              START;
    logic [CW-1:0]     CNT;
    logic [WIDTH-1:0]  Q;
    logic              BUSY;
    logic              DONE;

    modport master (
        output CE, MODE, DSR, DSL, D, START, CNT,
        input  Q, BUSY, DONE
    );

    modport slave (
        input  CE, MODE, DSR, DSL, D, START, CNT,
        output Q, BUSY, DONE
    );
endinterface

// File: rtl/ttl_univ_shift_step.sv
// One application of a mode to the register contents (purely combinational).
module ttl_univ_shift_step
    import ttl_univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  mode_e            mode,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q_next_c
);

    // Right moves Q[i] to Q[i+1]; left moves Q[i+1] to Q[i].
    always_comb begin
        q_next_c = q;
        case (mode)
            MODE_SR:   q_next_c = {q[WIDTH-2:0], dsr};
            MODE_SL:   q_next_c = {dsl, q[WIDTH-1:1]};
            MODE_LOAD: q_next_c = d;
            MODE_ROR:  q_next_c = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ROL:  q_next_c = {q[0], q[WIDTH-1:1]};
            MODE_SRX:  q_next_c = {q[WIDTH-2:0], q[0]};
            MODE_CLR:  q_next_c = '0;
            default:   q_next_c = q;
        endcase
    end

endmodule

// File: rtl/ttl_univ_shift_n.sv
// N-bit universal shift register with clock enable and counted burst engine.
module ttl_univ_shift_n
    import ttl_univ_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CW    = 4
) (
    input  logic            CP,
    input  logic            CR,
    ttl_univ_shift_if.slave bus
);

    logic [WIDTH-1:0] q_r, q_nxt, step_q_c;
    logic [CW-1:0]    rem_r, rem_nxt;
    mode_e            lat_mode_r, lat_mode_nxt;
    mode_e            in_mode, step_mode;
    state_e           state_r, state_nxt;
    logic             done_r, done_nxt;

    assign in_mode = mode_e'(bus.MODE);

    // A running burst repeats the latched mode; otherwise the live mode applies.
    always_comb begin
        step_mode = in_mode;
        if (state_r == ST_RUN) begin
            step_mode = lat_mode_r;
        end
    end

    ttl_univ_shift_step #(.WIDTH(WIDTH)) u_step (
        .q        (q_r),
        .mode     (step_mode),
        .dsr      (bus.DSR),
        .dsl      (bus.DSL),
        .d        (bus.D),
        .q_next_c (step_q_c)
    );

    // Next-state: direct operation, burst start and burst run.
    always_comb begin
        q_nxt        = q_r;
        rem_nxt      = rem_r;
        lat_mode_nxt = lat_mode_r;
        state_nxt    = state_r;
        done_nxt     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.CE) begin
                    if (bus.START && is_shift_mode(in_mode)) begin
                        // Start edge only arms the engine; no shift yet.
                        lat_mode_nxt = in_mode;
                        rem_nxt      = bus.CNT;
                        if (bus.CNT != CW'(0)) begin
                            state_nxt = ST_RUN;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end else begin
                        q_nxt = step_q_c;
                    end
                end
            end
            ST_RUN: begin
                if (bus.CE) begin
                    q_nxt   = step_q_c;
                    rem_nxt = rem_r - CW'(1);
                    if (rem_r == CW'(1)) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register with synchronous clear overriding everything.
    always_ff @(posedge CP) begin
        if (CR) begin
            q_r        <= '0;
            rem_r      <= '0;
            lat_mode_r <= MODE_HOLD;
            state_r    <= ST_IDLE;
            done_r     <= 1'b0;
        end else begin
            q_r        <= q_nxt;
            rem_r      <= rem_nxt;
            lat_mode_r <= lat_mode_nxt;
            state_r    <= state_nxt;
            done_r     <= done_nxt;
        end
    end

    assign bus.Q    = q_r;
    assign bus.BUSY = (state_r == ST_RUN);
    assign bus.DONE = done_r;

endmodule
